sync_fifo_fwft: RTL and testbench
=================================

# sync_fifo_fwft

Parametrised single-clock FIFO, successor to the current `sync_fifo`. Adds a selectable show-ahead (first-word-fall-through) read mode, arbitrary non-power-of-two depth, an underflow pulse, and defined full/empty behaviour for simultaneous read and write. Sits between a streaming producer and consumer in the same clock domain, as a drop-in replacement for `sync_fifo` when `SHOWAHEAD=0`.

## Interface
- `DATA_WIDTH`, 8, data word width (>=1)
- `DEPTH`, 8, number of entries (>=2, any integer; power of two not required)
- `AF_LEVEL`, 1, almost_full asserts when usedw >= DEPTH-AF_LEVEL
- `AE_LEVEL`, 1, almost_empty asserts when usedw <= AE_LEVEL
- `SHOWAHEAD`, 0, 0 = registered read (dout valid after the rd_en edge); 1 = FWFT (dout shows head word while !empty)

- `clk`  in  1  single clock; all logic on rising edge
- `aclr_n`  in  1  reset, asynchronous, active-low
- `sclr_n`  in  1  synchronous clear, active-low
- `din`  in  DATA_WIDTH  write data
- `wr_en`  in  1  write request
- `rd_en`  in  1  read request (pop)
- `dout`  out  DATA_WIDTH  read data
- `full`  out  1  usedw == DEPTH
- `almost_full`  out  1  usedw >= DEPTH-AF_LEVEL
- `empty`  out  1  usedw == 0
- `almost_empty`  out  1  usedw <= AE_LEVEL
- `overflow`  out  1  one-cycle pulse: rejected write
- `underflow`  out  1  one-cycle pulse: rejected read
- `usedw`  out  $clog2(DEPTH+1)  occupancy

## Operation
- Storage: DEPTH x DATA_WIDTH array; wr_ptr/rd_ptr are $clog2(DEPTH) bits, increment by 1, wrap DEPTH-1 -> 0 (explicit compare, not modulo-2^n).
- Accepted write = wr_en && (!full || accepted read this cycle). Stores din at wr_ptr, advances wr_ptr.
- Accepted read = rd_en && !empty. Advances rd_ptr.
- usedw: +1 write only, -1 read only, unchanged both or neither.
- Full + wr_en + rd_en: both accepted, usedw stays DEPTH, no overflow.
- Empty + wr_en + rd_en: write accepted, read rejected, underflow pulses, usedw -> 1.
- wr_en while full without read: data dropped, overflow = 1 for one cycle, state unchanged.
- rd_en while empty: underflow = 1 for one cycle, dout unchanged (SHOWAHEAD=0).
- SHOWAHEAD=0: on accepted read, dout <= mem[rd_ptr] at that edge; otherwise dout holds.
- SHOWAHEAD=1: dout = mem[rd_ptr] combinationally; value undefined-but-stable (last stored) when empty; rd_en acknowledges the displayed word.
- Flags derived from registered usedw; all update on the same edge as usedw.
- sclr_n = 0 at an edge: pointers, usedw, overflow, underflow, registered dout -> reset values; overrides wr_en/rd_en. Memory contents not cleared.
- aclr_n = 0: immediate reset regardless of clk; takes priority over sclr_n.

## Timing
- Reset values (aclr_n or sclr_n): usedw=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0 (registered mode).
- Write latency: din at edge N -> usedw/empty updated after edge N; readable from edge N+1.
- SHOWAHEAD=0 read latency: rd_en sampled at edge N -> dout valid after edge N.
- SHOWAHEAD=1: word written at edge N visible on dout after edge N (empty deasserts at same edge).
- overflow/underflow registered, asserted for exactly the cycle after the offending edge; consecutive offending cycles keep it high.
- Reset mid-operation: any in-flight write/read at the clearing edge is discarded.

## Test plan
- Reset: aclr_n=0 for 10 ns, then sclr_n=0 for one edge -> all outputs at reset values both during and after each.
- Fill/drain, SHOWAHEAD=0, DEPTH=8: write 8 random words -> full=1, usedw=8, almost_full=1; 8 reads -> same order, empty=1, usedw=0.
- Thresholds, AF_LEVEL=AE_LEVEL=1: at usedw=7 -> almost_full=1, full=0; at usedw=1 -> almost_empty=1, empty=0.
- Overflow/underflow: write 0x56 when full -> overflow=1 one cycle, usedw=8, 0x56 never read; read when empty -> underflow=1, usedw=0.
- Simultaneous: full + wr/rd with din=0xA5 -> usedw stays 8, 0xA5 read last; empty + wr/rd -> usedw=1, underflow=1.
- Wrap and mode: DEPTH=6, SHOWAHEAD=1, write/read i=0..17 interleaved -> dout==i before each pop, pointers wrap 5->0 with no data loss.

Source files
------------

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with optional first-word-fall-through read, any depth >= 2
// Ports: clk; aclr_n async clear; sclr_n sync clear; din/wr_en push; rd_en pop; dout read data;
// full/almost_full/empty/almost_empty from usedw; overflow/underflow one-cycle reject pulses.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 1,
  parameter int AE_LEVEL   = 1,
  parameter bit SHOWAHEAD  = 0,
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  sclr_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [CW-1:0]         usedw
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         usedw_q, usedw_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_acc, rd_acc;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
  always_comb begin
    rd_acc   = sclr_n && rd_en && (usedw_q != '0);
    wr_acc   = sclr_n && wr_en && ((usedw_q != CW'(DEPTH)) || rd_acc);
    wr_ptr_d = !sclr_n ? '0 : wr_acc ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = !sclr_n ? '0 : rd_acc ? inc(rd_ptr_q) : rd_ptr_q;
    usedw_d  = !sclr_n ? '0 : (wr_acc && !rd_acc) ? usedw_q + CW'(1) :
               (rd_acc && !wr_acc) ? usedw_q - CW'(1) : usedw_q;
    ovf_d    = sclr_n && wr_en && !wr_acc;
    unf_d    = sclr_n && rd_en && !rd_acc;
    dout_d   = !sclr_n ? '0 : rd_acc ? mem_q[rd_ptr_q] : dout_q;
  end

  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end

  // Storage is never cleared; only pointers and occupancy are.
  always_ff @(posedge clk)
    if (wr_acc) mem_q[wr_ptr_q] <= din;

  assign dout         = SHOWAHEAD ? mem_q[rd_ptr_q] : dout_q;
  assign usedw        = usedw_q;
  assign full         = usedw_q == CW'(DEPTH);
  assign almost_full  = usedw_q >= CW'(DEPTH - AF_LEVEL);
  assign empty        = usedw_q == '0;
  assign almost_empty = usedw_q <= CW'(AE_LEVEL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed vectors for a registered DEPTH=8 FIFO and a FWFT DEPTH=6 FIFO
module tb_sync_fifo_fwft;
  logic       clk = 1'b0;
  logic       aclr_n = 1'b1;
  logic       sclr_n = 1'b1;
  logic [7:0] din0 = '0, din1 = '0;
  logic       wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
  logic [7:0] dout0, dout1;
  logic       full0, af0, empty0, ae0, ovf0, unf0;
  logic       full1, af1, empty1, ae1, ovf1, unf1;
  logic [3:0] usedw0;
  logic [2:0] usedw1;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(1), .AE_LEVEL(1), .SHOWAHEAD(0)) dut0 (
    .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .din(din0), .wr_en(wr0), .rd_en(rd0),
    .dout(dout0), .full(full0), .almost_full(af0), .empty(empty0), .almost_empty(ae0),
    .overflow(ovf0), .underflow(unf0), .usedw(usedw0));

  sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(6), .AF_LEVEL(1), .AE_LEVEL(1), .SHOWAHEAD(1)) dut1 (
    .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n), .din(din1), .wr_en(wr1), .rd_en(rd1),
    .dout(dout1), .full(full1), .almost_full(af1), .empty(empty1), .almost_empty(ae1),
    .overflow(ovf1), .underflow(unf1), .usedw(usedw1));

  typedef struct packed {
    logic       sclr_n;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] usedw;
    logic [5:0] flags;
  } vec_t;

  vec_t vec [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] st0();
    return {dout0, usedw0, full0, af0, empty0, ae0, ovf0, unf0};
  endfunction

  initial begin
    // flags = {full, almost_full, empty, almost_empty, overflow, underflow}
    vec[0]  = '{1'b0, 1'b1, 1'b0, 8'h99, 8'h00, 4'd0, 6'b001100};
    vec[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 6'b001101};
    vec[2]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 8'h00, 4'd1, 6'b000101};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h3C, 4'd0, 6'b001100};
    vec[4]  = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h3C, 4'd1, 6'b000100};
    vec[5]  = '{1'b1, 1'b1, 1'b0, 8'h21, 8'h3C, 4'd2, 6'b000000};
    vec[6]  = '{1'b1, 1'b1, 1'b0, 8'h32, 8'h3C, 4'd3, 6'b000000};
    vec[7]  = '{1'b1, 1'b1, 1'b0, 8'h43, 8'h3C, 4'd4, 6'b000000};
    vec[8]  = '{1'b1, 1'b1, 1'b0, 8'h54, 8'h3C, 4'd5, 6'b000000};
    vec[9]  = '{1'b1, 1'b1, 1'b0, 8'h65, 8'h3C, 4'd6, 6'b000000};
    vec[10] = '{1'b1, 1'b1, 1'b0, 8'h76, 8'h3C, 4'd7, 6'b010000};
    vec[11] = '{1'b1, 1'b1, 1'b0, 8'h87, 8'h3C, 4'd8, 6'b110000};
    vec[12] = '{1'b1, 1'b1, 1'b0, 8'h56, 8'h3C, 4'd8, 6'b110010};
    vec[13] = '{1'b1, 1'b1, 1'b0, 8'h56, 8'h3C, 4'd8, 6'b110010};
    vec[14] = '{1'b1, 1'b1, 1'b1, 8'hA5, 8'h10, 4'd8, 6'b110000};
    vec[15] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h21, 4'd7, 6'b010000};
    vec[16] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h32, 4'd6, 6'b000000};
    vec[17] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h43, 4'd5, 6'b000000};
    vec[18] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h54, 4'd4, 6'b000000};
    vec[19] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h65, 4'd3, 6'b000000};
    vec[20] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h76, 4'd2, 6'b000000};
    vec[21] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h87, 4'd1, 6'b000100};
    vec[22] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hA5, 4'd0, 6'b001100};
    vec[23] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hA5, 4'd0, 6'b001101};
    vec[24] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 4'd0, 6'b001100};
    vec[25] = '{1'b1, 1'b1, 1'b0, 8'h77, 8'hA5, 4'd1, 6'b000100};
    vec[26] = '{1'b0, 1'b1, 1'b1, 8'h88, 8'h00, 4'd0, 6'b001100};
    vec[27] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 6'b001101};

    #1 aclr_n = 1'b0;
    #9;
    chk("aclr_dut0", 32'(st0()), 32'({8'h00, 4'd0, 6'b001100}));
    chk("aclr_dut1", 32'({usedw1, full1, af1, empty1, ae1, ovf1, unf1}), 32'({3'd0, 6'b001100}));
    #2 aclr_n = 1'b1;

    foreach (vec[i]) begin
      @(negedge clk);
      sclr_n = vec[i].sclr_n;
      wr0    = vec[i].wr;
      rd0    = vec[i].rd;
      din0   = vec[i].din;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), 32'(st0()), 32'({vec[i].dout, vec[i].usedw, vec[i].flags}));
    end

    @(negedge clk);
    sclr_n = 1'b1;
    rd0    = 1'b0;
    wr0    = 1'b1;
    din0   = 8'h11;
    @(negedge clk);
    wr0 = 1'b0;
    #2 aclr_n = 1'b0;
    #1 chk("aclr_async", 32'(st0()), 32'({8'h00, 4'd0, 6'b001100}));
    #1 aclr_n = 1'b1;

    @(negedge clk);
    wr1  = 1'b1;
    din1 = 8'd0;
    @(posedge clk);
    #1 chk("fwft_first", 32'({dout1, empty1}), 32'({8'd0, 1'b0}));
    @(negedge clk);
    din1 = 8'd1;
    @(negedge clk);
    din1 = 8'd2;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk($sformatf("fwft_pop%0d", i), 32'({dout1, empty1}), 32'({8'(i), 1'b0}));
      rd1  = 1'b1;
      wr1  = (i + 3 < 18);
      din1 = 8'(i + 3);
    end
    @(negedge clk);
    rd1 = 1'b0;
    wr1 = 1'b0;
    chk("fwft_drained", 32'({usedw1, empty1, unf1, ovf1}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
